// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched -- round-robin scheduler for a shared programmable clock divider.
//
// A single divider is time-shared between N_REQ requesters. In IDLE the block
// picks the next requester after the last one served. It latches that
// requester's divisor and the burst length, and then produces burst_len divided
// ticks for it. The grant is released early if the requester drops its request.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   req        per-requester request level
//   div_val    packed divisors, requester i at [i*W +: W]
//   burst_len  ticks per grant (0 = 2^W)
//   gnt        registered one-hot grant (LOAD and RUN only)
//   tick       one-cycle divided-clock enable (RUN only)
//   div_out    divided square wave, toggles on each tick, 0 at release
//   busy       high in LOAD and RUN
//   done       one-cycle pulse in RELEASE
//   aborted    qualifies done: release caused by a request drop
// -----------------------------------------------------------------------------
module div_sched #(
   parameter int N_REQ = 4,
   parameter int W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] div_val,
   input  logic [W-1:0]       burst_len,
   output logic [N_REQ-1:0]   gnt,
   output logic               tick,
   output logic               div_out,
   output logic               busy,
   output logic               done,
   output logic               aborted
);

   localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = W + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_REL} state_t;

   state_t           r_state, w_next;
   logic [SW-1:0]    r_sel, r_last, w_pick;
   logic             w_found;
   int               w_idx;
   logic [N_REQ-1:0] r_gnt;
   logic [W-1:0]     r_div, r_cnt;
   logic [TW-1:0]    r_burst, r_tcnt;
   logic             r_div_out, r_aborted;
   logic             w_tick, w_last_tick, w_abort;
   logic [W-1:0]     w_divs [N_REQ];

   // Unpack the flat divisor bus so the selected lane is a plain array read.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) w_divs[i] = div_val[i*W +: W];
   end

   // Round-robin pick: scan from last+1 and wrap, first active request wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_last;
      w_idx   = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         w_idx = (int'(r_last) + off) % N_REQ;
         if (!w_found && req[SW'(w_idx)]) begin
            w_found = 1'b1;
            w_pick  = SW'(w_idx);
         end
      end
   end

   assign w_tick      = (r_state == S_RUN) && (r_cnt == r_div);
   // Burst compare is one bit wider so burst_len 0 can mean 2^W ticks.
   assign w_last_tick = w_tick && ((r_tcnt + TW'(1)) == r_burst);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_abort = 1'b0;
      case (r_state)
         S_IDLE: if (w_found) w_next = S_LOAD;
         S_LOAD: w_next = S_RUN;
         S_RUN: begin
            // A drop that coincides with the final tick counts as a normal end.
            if (w_last_tick) begin
               w_next = S_REL;
            end else if (!req[r_sel]) begin
               w_next  = S_REL;
               w_abort = 1'b1;
            end
         end
         S_REL:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt     <= '0;
         r_sel     <= '0;
         r_last    <= SW'(N_REQ - 1);
         r_div     <= '0;
         r_burst   <= '0;
         r_cnt     <= '0;
         r_tcnt    <= '0;
         r_div_out <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_aborted <= 1'b0;
               if (w_found) begin
                  r_sel <= w_pick;
                  r_gnt <= N_REQ'(1) << w_pick;
               end
            end
            S_LOAD: begin
               r_div     <= w_divs[r_sel];
               r_burst   <= (burst_len == '0) ? {1'b1, {W{1'b0}}} : {1'b0, burst_len};
               r_cnt     <= '0;
               r_tcnt    <= '0;
               r_div_out <= 1'b0;
            end
            S_RUN: begin
               if (w_tick) begin
                  r_cnt     <= '0;
                  r_tcnt    <= r_tcnt + TW'(1);
                  r_div_out <= ~r_div_out;
               end else begin
                  r_cnt <= r_cnt + W'(1);
               end
               // Leaving RUN: drop the grant and park div_out low for RELEASE.
               if (w_next == S_REL) begin
                  r_gnt     <= '0;
                  r_div_out <= 1'b0;
                  r_aborted <= w_abort;
               end
            end
            S_REL:   r_last <= r_sel;
            default: ;
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign tick    = w_tick;
   assign div_out = r_div_out;
   assign busy    = (r_state == S_LOAD) || (r_state == S_RUN);
   assign done    = (r_state == S_REL);
   assign aborted = (r_state == S_REL) && r_aborted;

endmodule

// File: tb/tb_div_sched.sv
// -----------------------------------------------------------------------------
// tb_div_sched -- self-checking bench for div_sched (N_REQ=4, W=8).
// A table of grant scenarios is driven one by one; each scenario pushes its
// expected outcome to a queue. A monitor measures every grant (requester, tick
// count, first-tick position, tick period, div_out waveform, abort flag) and
// compares it against the popped entry when done pulses. Hand-written
// sequences cover reset, round-robin rotation and reset during RUN.
// -----------------------------------------------------------------------------
module tb_div_sched;

   logic        clk, rst;
   logic [3:0]  req;
   logic [31:0] div_val;
   logic [7:0]  burst_len;
   logic [3:0]  gnt;
   logic        tick, div_out, busy, done, aborted;

   div_sched #(.N_REQ(4), .W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .div_val(div_val), .burst_len(burst_len),
      .gnt(gnt), .tick(tick), .div_out(div_out), .busy(busy), .done(done),
      .aborted(aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] dv;
      logic [31:0] dv2;     // div_val applied during RUN (must be ignored)
      logic [7:0]  bl;
      logic [7:0]  bl2;     // burst_len applied during RUN (must be ignored)
      int          drop;    // drop req at this tick number, 0 = never
      logic [3:0]  egnt;
      int          eticks;
      int          ediv;
      logic        eab;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      int         ticks;
      int         div;
      logic       ab;
   } exp_t;

   exp_t q[$];
   vec_t vt[8];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic       m_act = 1'b0;
   logic [3:0] m_gnt;
   int         m_cyc, m_ticks, m_first, m_last, m_min, m_max;
   int         m_dv_err, m_gchg, ri, iv, n_tick_idle = 0;
   logic       m_dv;
   exp_t       me;

   always @(negedge clk) begin
      // Active grant that vanished without a release means a reset hit it.
      if (m_act && !busy && !done) m_act = 1'b0;
      if (tick && !busy) n_tick_idle++;
      if (!m_act && gnt != 4'b0) begin
         m_act = 1'b1; m_gnt = gnt; m_cyc = 0; m_ticks = 0; m_first = 0;
         m_last = 0; m_min = 1 << 30; m_max = -1; m_dv = 1'b0;
         m_dv_err = 0; m_gchg = 0;
      end
      if (m_act) begin
         m_cyc++;
         if (done) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL sb_pop: done with no expected entry at %0t", $time);
            end else begin
               me = q.pop_front();
               chk("sb_gnt", int'(m_gnt), int'(me.gnt));
               chk("sb_ticks", m_ticks, me.ticks);
               if (me.ticks > 0) chk("sb_first", m_first, me.div + 1);
               if (me.ticks > 1) begin
                  chk("sb_pmin", m_min, me.div + 1);
                  chk("sb_pmax", m_max, me.div + 1);
               end
               chk("sb_abort", int'(aborted), int'(me.ab));
               chk("sb_divout_rel", int'(div_out), 0);
               chk("sb_gnt_rel", int'(gnt), 0);
               chk("sb_divout_wave", m_dv_err, 0);
               chk("sb_gnt_stable", m_gchg, 0);
            end
            m_act = 1'b0;
         end else begin
            if (gnt != m_gnt) m_gchg++;
            if (div_out != m_dv) m_dv_err++;
            if (tick) begin
               ri = m_cyc - 1;   // RUN cycle number, LOAD is m_cyc 1
               if (m_ticks > 0) begin
                  iv = ri - m_last;
                  if (iv < m_min) m_min = iv;
                  if (iv > m_max) m_max = iv;
               end else begin
                  m_first = ri;
               end
               m_last = ri;
               m_ticks++;
               m_dv = ~m_dv;
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Called at a negedge with the DUT idle; returns one cycle after done.
   task automatic run_vec(input vec_t v);
      int   n, t;
      logic ok;
      exp_t e;
      req = v.req; div_val = v.dv; burst_len = v.bl;
      e.gnt = v.egnt; e.ticks = v.eticks; e.div = v.ediv; e.ab = v.eab;
      q.push_back(e);
      n = 0;
      while (gnt == 4'b0 && n < 20) begin @(negedge clk); n++; end
      chk("lat", n, 1);
      n = 0; t = 0; ok = 1'b0;
      while (n < 3000) begin
         @(negedge clk); n++;
         if (n == 1) begin div_val = v.dv2; burst_len = v.bl2; end
         if (tick) begin
            t++;
            if (v.drop == t) req = 4'b0;
         end
         if (done) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL timeout: no done for req %b after %0d cycles", v.req, n);
      end
      req = 4'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [3:0] eg;

   initial begin
      vt[0] = '{4'b0001, 32'h0A0B0C03, 32'h0A0B0C03, 8'd2, 8'd2, 0, 4'b0001,   2, 3, 1'b0};
      vt[1] = '{4'b0011, 32'h0000050E, 32'h0000020E, 8'd3, 8'd3, 0, 4'b0010,   3, 5, 1'b0};
      vt[2] = '{4'b0101, 32'h01090304, 32'h01090304, 8'd5, 8'd5, 2, 4'b0100,   2, 9, 1'b1};
      vt[3] = '{4'b1001, 32'h00030303, 32'h00030303, 8'd4, 8'd4, 4, 4'b1000,   4, 0, 1'b0};
      vt[4] = '{4'b1110, 32'h03030103, 32'h03030103, 8'd3, 8'd1, 0, 4'b0010,   3, 1, 1'b0};
      vt[5] = '{4'b0001, 32'h05050500, 32'h05050500, 8'd0, 8'd0, 0, 4'b0001, 256, 0, 1'b0};
      vt[6] = '{4'b0100, 32'h00070000, 32'h00070000, 8'd1, 8'd1, 0, 4'b0100,   1, 7, 1'b0};
      vt[7] = '{4'b1111, 32'h02000000, 32'h02000000, 8'd2, 8'd2, 0, 4'b1000,   2, 2, 1'b0};

      rst = 1'b1; req = 4'b0; div_val = '0; burst_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_divout", int'(div_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_aborted", int'(aborted), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vt[i]);

      // Round-robin rotation with all requests held, one tick per grant.
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      req = 4'hF; div_val = '0; burst_len = 8'd1;
      for (int k = 0; k < 5; k++) q.push_back('{4'b0001 << (k % 4), 1, 0, 1'b0});
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         eg = (((c - 1) % 4) < 2) ? (4'b0001 << (((c - 1) / 4) % 4)) : 4'b0000;
         chk("rot_gnt", int'(gnt), int'(eg));
         if (c == 19) req = 4'b0;
      end

      // Reset in the middle of a RUN for requester 1.
      req = 4'b0010; div_val = 32'h00000500; burst_len = 8'd10;
      repeat (8) @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_gnt", int'(gnt), 0);
      chk("mid_rst_tick", int'(tick), 0);
      chk("mid_rst_divout", int'(div_out), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_aborted", int'(aborted), 0);
      rst = 1'b0; req = 4'b0;
      @(negedge clk);
      run_vec('{4'b1000, 32'h04000000, 32'h04000000, 8'd1, 8'd1, 0, 4'b1000, 1, 4, 1'b0});
      run_vec('{4'b0011, 32'h00000101, 32'h00000101, 8'd2, 8'd2, 0, 4'b0001, 2, 1, 1'b0});

      chk("sb_empty", q.size(), 0);
      chk("tick_idle", n_tick_idle, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
